// File: rtl/video_timing_pkg.sv
// Shared types and default widths for the video timing meter.
package video_timing_pkg;
  localparam int HCNT_W_DEF      = 12;
  localparam int VCNT_W_DEF      = 11;
  localparam int LOCK_FRAMES_DEF = 2;
  localparam int TO_W_DEF        = 24;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } vtm_state_e;
endpackage

// File: rtl/vtm_line_meter.sv
// Per-line sample counter: total, de and hs samples from one hs rise up to the next.
module vtm_line_meter
  import video_timing_pkg::*;
#(
  parameter int HCNT_W = HCNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ce_i,
  input  logic              hs_i,
  input  logic              de_i,
  input  logic              hs_rise_i,
  input  logic              restart_i,
  output logic              done_o,
  output logic [HCNT_W-1:0] total_o,
  output logic [HCNT_W-1:0] active_o,
  output logic [HCNT_W-1:0] sync_o,
  output logic              sat_o
);
  localparam logic [HCNT_W-1:0] HMAX = '1;

  function automatic logic [HCNT_W-1:0] sat_inc(input logic [HCNT_W-1:0] v);
    return (v == HMAX) ? v : v + 1'b1;
  endfunction

  logic [HCNT_W-1:0] total_q, total_d, active_q, active_d, sync_q, sync_d;
  logic              sat_q, sat_d, started_q, started_d;

  always_comb begin
    total_d   = total_q;
    active_d  = active_q;
    sync_d    = sync_q;
    sat_d     = sat_q;
    started_d = started_q;
    if (restart_i) begin
      total_d   = '0;
      active_d  = '0;
      sync_d    = '0;
      sat_d     = 1'b0;
      started_d = 1'b0;
    end else if (ce_i) begin
      if (hs_rise_i) begin
        // The rising sample is the first sample of the new line.
        started_d = 1'b1;
        total_d   = HCNT_W'(1);
        active_d  = HCNT_W'(de_i);
        sync_d    = HCNT_W'(1);
        sat_d     = 1'b0;
      end else begin
        total_d = sat_inc(total_q);
        if (de_i) active_d = sat_inc(active_q);
        if (hs_i) sync_d = sat_inc(sync_q);
        sat_d = sat_q | (total_d == HMAX) | (active_d == HMAX) | (sync_d == HMAX);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      total_q   <= '0;
      active_q  <= '0;
      sync_q    <= '0;
      sat_q     <= 1'b0;
      started_q <= 1'b0;
    end else begin
      total_q   <= total_d;
      active_q  <= active_d;
      sync_q    <= sync_d;
      sat_q     <= sat_d;
      started_q <= started_d;
    end
  end

  assign done_o   = hs_rise_i & started_q & ~restart_i;
  assign total_o  = total_q;
  assign active_o = active_q;
  assign sync_o   = sync_q;
  assign sat_o    = sat_q;
endmodule

// File: rtl/video_timing_meter.sv
// Measures line/frame timing of a sync+de stream and publishes it once stable.
module video_timing_meter
  import video_timing_pkg::*;
#(
  parameter int HCNT_W      = HCNT_W_DEF,
  parameter int VCNT_W      = VCNT_W_DEF,
  parameter int LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int TO_W        = TO_W_DEF
) (
  input  logic              clk_vid,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              hs,
  input  logic              vs,
  input  logic              de,
  output logic [HCNT_W-1:0] h_total,
  output logic [HCNT_W-1:0] h_active,
  output logic [HCNT_W-1:0] h_sync,
  output logic [VCNT_W-1:0] v_total,
  output logic [VCNT_W-1:0] v_active,
  output logic [VCNT_W-1:0] v_sync,
  output logic              locked,
  output logic              frame_stb
);
  localparam int              MW     = $clog2(LOCK_FRAMES + 1);
  localparam logic [VCNT_W-1:0] VMAX   = '1;
  localparam logic [TO_W-1:0]   TO_MAX = '1;

  function automatic logic [VCNT_W-1:0] vinc(input logic [VCNT_W-1:0] v);
    return (v == VMAX) ? v : v + 1'b1;
  endfunction

  logic hs_prev_q, vs_prev_q, hs_rise, vs_rise;
  logic [TO_W-1:0] to_q, to_d;
  logic to_hit;

  assign hs_rise = ce_pix & hs & ~hs_prev_q;
  assign vs_rise = ce_pix & vs & ~vs_prev_q;
  assign to_d    = vs_rise ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);
  assign to_hit  = (to_d == TO_MAX);

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      to_q      <= '0;
    end else begin
      to_q <= to_d;
      if (ce_pix) begin
        hs_prev_q <= hs;
        vs_prev_q <= vs;
      end
    end
  end

  logic              ln_done, ln_sat;
  logic [HCNT_W-1:0] ln_total, ln_active, ln_sync;

  vtm_line_meter #(.HCNT_W(HCNT_W)) u_line (
    .clk_i    (clk_vid),
    .rst_ni   (reset_n),
    .ce_i     (ce_pix),
    .hs_i     (hs),
    .de_i     (de),
    .hs_rise_i(hs_rise),
    .restart_i(to_hit),
    .done_o   (ln_done),
    .total_o  (ln_total),
    .active_o (ln_active),
    .sync_o   (ln_sync),
    .sat_o    (ln_sat)
  );

  logic              have_q, have_d, bad_q, bad_d, seen_q, seen_d;
  logic [HCNT_W-1:0] first_q, first_d, lt_q, lt_d, la_q, la_d, ls_q, ls_d;
  logic [VCNT_W-1:0] vt_q, vt_d, va_q, va_d, vy_q, vy_d;
  logic              fe_have, fe_bad, new_de;
  logic [HCNT_W-1:0] fe_first, fe_t, fe_a, fe_s;

  // Frame view including a line that completes on this very sample.
  assign fe_have  = have_q | ln_done;
  assign fe_first = have_q ? first_q : ln_total;
  assign fe_bad   = bad_q | (ln_done & (ln_sat | (have_q & (ln_total != first_q))));
  assign fe_t     = ln_done ? ln_total  : lt_q;
  assign fe_a     = ln_done ? ln_active : la_q;
  assign fe_s     = ln_done ? ln_sync   : ls_q;
  assign new_de   = ce_pix & de & (hs_rise | ~seen_q);

  always_comb begin
    have_d  = have_q;  bad_d = bad_q;  seen_d = seen_q;  first_d = first_q;
    lt_d    = lt_q;    la_d  = la_q;   ls_d   = ls_q;
    vt_d    = vt_q;    va_d  = va_q;   vy_d   = vy_q;
    if (to_hit) begin
      have_d = 1'b0; bad_d = 1'b0; seen_d = 1'b0; first_d = '0;
      lt_d   = '0;   la_d  = '0;   ls_d   = '0;
      vt_d   = '0;   va_d  = '0;   vy_d   = '0;
    end else if (ce_pix) begin
      seen_d = hs_rise ? de : (seen_q | de);
      if (vs_rise) begin
        have_d = 1'b0; bad_d = 1'b0; first_d = '0;
        lt_d   = '0;   la_d  = '0;   ls_d    = '0;
        vt_d   = VCNT_W'(hs_rise);
        vy_d   = VCNT_W'(hs_rise);
        va_d   = VCNT_W'(new_de);
      end else begin
        have_d  = fe_have;
        first_d = fe_first;
        lt_d    = fe_t;
        la_d    = fe_a;
        ls_d    = fe_s;
        if (hs_rise) vt_d = vinc(vt_q);
        if (hs_rise & vs) vy_d = vinc(vy_q);
        if (new_de) va_d = vinc(va_q);
        bad_d = fe_bad | (vt_d == VMAX) | (va_d == VMAX) | (vy_d == VMAX);
      end
    end
  end

  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      have_q <= 1'b0; bad_q <= 1'b0; seen_q <= 1'b0; first_q <= '0;
      lt_q   <= '0;   la_q  <= '0;   ls_q   <= '0;
      vt_q   <= '0;   va_q  <= '0;   vy_q   <= '0;
    end else begin
      have_q <= have_d; bad_q <= bad_d; seen_q <= seen_d; first_q <= first_d;
      lt_q   <= lt_d;   la_q  <= la_d;  ls_q   <= ls_d;
      vt_q   <= vt_d;   va_q  <= va_d;  vy_q   <= vy_d;
    end
  end

  vtm_state_e        state_q;
  logic [MW-1:0]     match_q;
  logic              started_q, locked_q, stb_q, f_valid, f_match;
  logic [HCNT_W-1:0] c_ht_q, c_ha_q, c_hs_q, o_ht_q, o_ha_q, o_hs_q;
  logic [VCNT_W-1:0] c_vt_q, c_va_q, c_vs_q, o_vt_q, o_va_q, o_vs_q;

  assign f_valid = fe_have & ~fe_bad;
  assign f_match = (fe_t == c_ht_q) && (fe_a == c_ha_q) && (fe_s == c_hs_q) &&
                   (vt_q == c_vt_q) && (va_q == c_va_q) && (vy_q == c_vs_q);

  // Leaving lock restarts measurement, so the next frame only re-arms the meter.
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH; match_q <= '0; started_q <= 1'b0;
      locked_q <= 1'b0; stb_q <= 1'b0;
      c_ht_q <= '0; c_ha_q <= '0; c_hs_q <= '0; c_vt_q <= '0; c_va_q <= '0; c_vs_q <= '0;
      o_ht_q <= '0; o_ha_q <= '0; o_hs_q <= '0; o_vt_q <= '0; o_va_q <= '0; o_vs_q <= '0;
    end else begin
      stb_q <= 1'b0;
      if (to_hit) begin
        state_q <= SEARCH; locked_q <= 1'b0; started_q <= 1'b0; match_q <= '0;
      end else if (vs_rise) begin
        started_q <= 1'b1;
        if (started_q) begin
          case (state_q)
            SEARCH: begin
              if (f_valid) begin
                c_ht_q <= fe_t; c_ha_q <= fe_a; c_hs_q <= fe_s;
                c_vt_q <= vt_q; c_va_q <= va_q; c_vs_q <= vy_q;
                match_q <= MW'(1);
                state_q <= CHECK;
              end else begin
                started_q <= 1'b0;
              end
            end
            CHECK: begin
              if (!f_valid) begin
                state_q <= SEARCH; match_q <= '0; started_q <= 1'b0;
              end else if (f_match) begin
                if (match_q >= MW'(LOCK_FRAMES - 1)) begin
                  state_q <= LOCKED; match_q <= MW'(LOCK_FRAMES);
                  locked_q <= 1'b1; stb_q <= 1'b1;
                  o_ht_q <= fe_t; o_ha_q <= fe_a; o_hs_q <= fe_s;
                  o_vt_q <= vt_q; o_va_q <= va_q; o_vs_q <= vy_q;
                end else begin
                  match_q <= match_q + 1'b1;
                end
              end else begin
                c_ht_q <= fe_t; c_ha_q <= fe_a; c_hs_q <= fe_s;
                c_vt_q <= vt_q; c_va_q <= va_q; c_vs_q <= vy_q;
                match_q <= MW'(1);
              end
            end
            LOCKED: begin
              if (f_valid && f_match) begin
                stb_q <= 1'b1;
                o_ht_q <= fe_t; o_ha_q <= fe_a; o_hs_q <= fe_s;
                o_vt_q <= vt_q; o_va_q <= va_q; o_vs_q <= vy_q;
              end else begin
                state_q <= SEARCH; locked_q <= 1'b0; match_q <= '0; started_q <= 1'b0;
              end
            end
            default: state_q <= SEARCH;
          endcase
        end
      end
    end
  end

  assign h_total   = o_ht_q;
  assign h_active  = o_ha_q;
  assign h_sync    = o_hs_q;
  assign v_total   = o_vt_q;
  assign v_active  = o_va_q;
  assign v_sync    = o_vs_q;
  assign locked    = locked_q;
  assign frame_stb = stb_q;
endmodule

// File: tb/tb_video_timing_meter.sv
// Directed bench: default instance, a short-timeout instance and a narrow-counter instance share one stimulus.
module tb_video_timing_meter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ce_pix = 1'b0, hs = 1'b0, vs = 1'b0, de = 1'b0;

  logic [11:0] a_ht, a_ha, a_hs;  logic [10:0] a_vt, a_va, a_vs;  logic a_lk, a_stb;
  logic [11:0] b_ht, b_ha, b_hs;  logic [10:0] b_vt, b_va, b_vs;  logic b_lk, b_stb;
  logic [7:0]  c_ht, c_ha, c_hs;  logic [10:0] c_vt, c_va, c_vs;  logic c_lk, c_stb;

  int total = 0, bad = 0;
  int h_tot, h_act, h_syn, v_tot, v_act, v_syn, ce_div;
  int c_stb_n = 0, c_lk_n = 0;
  logic cnt_clr = 1'b1;

  always #5 clk = ~clk;

  video_timing_meter u_a (
    .clk_vid(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
    .h_total(a_ht), .h_active(a_ha), .h_sync(a_hs), .v_total(a_vt), .v_active(a_va),
    .v_sync(a_vs), .locked(a_lk), .frame_stb(a_stb));

  video_timing_meter #(.TO_W(8)) u_b (
    .clk_vid(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
    .h_total(b_ht), .h_active(b_ha), .h_sync(b_hs), .v_total(b_vt), .v_active(b_va),
    .v_sync(b_vs), .locked(b_lk), .frame_stb(b_stb));

  video_timing_meter #(.HCNT_W(8)) u_c (
    .clk_vid(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de),
    .h_total(c_ht), .h_active(c_ha), .h_sync(c_hs), .v_total(c_vt), .v_active(c_va),
    .v_sync(c_vs), .locked(c_lk), .frame_stb(c_stb));

  always @(posedge clk) begin
    if (cnt_clr) begin
      c_stb_n <= 0;
      c_lk_n  <= 0;
    end else begin
      if (c_stb) c_stb_n <= c_stb_n + 1;
      if (c_lk)  c_lk_n  <= c_lk_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int l, input int s);
    ce_pix = 1'b0;
    repeat (ce_div - 1) tick();
    hs = (s < h_syn);
    vs = (l < v_syn);
    de = (l >= v_tot - v_act) && (s >= h_tot - h_act);
    ce_pix = 1'b1;
    tick();
    ce_pix = 1'b0;
  endtask

  task automatic lines(input int l0, input int l1);
    for (int l = l0; l <= l1; l++)
      for (int s = 0; s < h_tot; s++) pix(l, s);
  endtask

  task automatic rest(input int last);
    for (int s = 1; s < h_tot; s++) pix(0, s);
    lines(1, last);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    ce_pix = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic small_fmt(input int div);
    h_tot = 20; h_act = 12; h_syn = 3; v_tot = 10; v_act = 6; v_syn = 2; ce_div = div;
  endtask

  initial begin
    small_fmt(4);
    do_reset();
    chk("rst_a_ht", a_ht, 0); chk("rst_a_ha", a_ha, 0); chk("rst_a_hs", a_hs, 0);
    chk("rst_a_vt", a_vt, 0); chk("rst_a_va", a_va, 0); chk("rst_a_vs", a_vs, 0);
    chk("rst_a_lk", a_lk, 0); chk("rst_a_stb", a_stb, 0);
    chk("rst_b_ht", b_ht, 0); chk("rst_b_ha", b_ha, 0); chk("rst_b_hs", b_hs, 0);
    chk("rst_b_vt", b_vt, 0); chk("rst_b_va", b_va, 0); chk("rst_b_vs", b_vs, 0);
    chk("rst_b_lk", b_lk, 0); chk("rst_b_stb", b_stb, 0);
    chk("rst_c_ht", c_ht, 0); chk("rst_c_ha", c_ha, 0); chk("rst_c_hs", c_hs, 0);
    chk("rst_c_vt", c_vt, 0); chk("rst_c_va", c_va, 0); chk("rst_c_vs", c_vs, 0);
    chk("rst_c_lk", c_lk, 0); chk("rst_c_stb", c_stb, 0);

    // Acquisition: lock on the third vs rise, ce_pix every 4th clock.
    pix(0, 0); chk("acq_r1_stb", a_stb, 0); chk("acq_r1_lk", a_lk, 0);
    rest(v_tot - 1);
    pix(0, 0); chk("acq_r2_stb", a_stb, 0); chk("acq_r2_lk", a_lk, 0);
    rest(v_tot - 1);
    pix(0, 0);
    chk("acq_r3_stb", a_stb, 1); chk("acq_r3_lk", a_lk, 1);
    chk("acq_ht", a_ht, 20); chk("acq_ha", a_ha, 12); chk("acq_hs", a_hs, 3);
    chk("acq_vt", a_vt, 10); chk("acq_va", a_va, 6); chk("acq_vs", a_vs, 2);
    tick(); chk("acq_stb_pulse", a_stb, 0);
    rest(v_tot - 1);
    pix(0, 0); chk("lk_r4_stb", a_stb, 1); chk("lk_r4_vt", a_vt, 10);

    // One 11-line frame drops lock; three more good frames relock.
    rest(v_tot);
    pix(0, 0);
    chk("long_lk", a_lk, 0); chk("long_stb", a_stb, 0);
    chk("long_vt_kept", a_vt, 10); chk("long_ht_kept", a_ht, 20);
    rest(v_tot - 1); pix(0, 0); chk("relock_g1_lk", a_lk, 0);
    rest(v_tot - 1); pix(0, 0); chk("relock_g2_lk", a_lk, 0); chk("relock_g2_stb", a_stb, 0);
    rest(v_tot - 1); pix(0, 0);
    chk("relock_g3_lk", a_lk, 1); chk("relock_g3_stb", a_stb, 1);
    chk("relock_vt", a_vt, 10); chk("relock_va", a_va, 6);

    // Asynchronous reset mid-frame while locked.
    rest(4);
    reset_n = 1'b0;
    #2;
    chk("mid_rst_lk", a_lk, 0); chk("mid_rst_stb", a_stb, 0);
    chk("mid_rst_ht", a_ht, 0); chk("mid_rst_vt", a_vt, 0);
    chk("mid_rst_ha", a_ha, 0); chk("mid_rst_vs", a_vs, 0);
    repeat (2) tick();
    reset_n = 1'b1;
    lines(5, v_tot - 1);
    pix(0, 0); chk("post_rst_r1_stb", a_stb, 0);
    rest(v_tot - 1);
    pix(0, 0); chk("post_rst_r2_stb", a_stb, 0); chk("post_rst_r2_lk", a_lk, 0);
    rest(v_tot - 1);
    pix(0, 0);
    chk("post_rst_r3_stb", a_stb, 1); chk("post_rst_r3_lk", a_lk, 1);
    chk("post_rst_ht", a_ht, 20); chk("post_rst_vt", a_vt, 10);

    // Timeout on the TO_W=8 instance once vs stops.
    small_fmt(1);
    do_reset();
    pix(0, 0); rest(v_tot - 1);
    pix(0, 0); rest(v_tot - 1);
    pix(0, 0);
    chk("to_lock_b", b_lk, 1); chk("to_stb_b", b_stb, 1);
    hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (254) tick();
    chk("to_254_lk", b_lk, 1);
    tick();
    chk("to_255_lk", b_lk, 0);
    chk("to_kept_ht", b_ht, 20); chk("to_kept_ha", b_ha, 12);
    chk("to_kept_vt", b_vt, 10); chk("to_kept_vs", b_vs, 2);

    // 800-sample lines: 8-bit counters saturate, 12-bit counters lock normally.
    h_tot = 800; h_act = 640; h_syn = 96; v_tot = 3; v_act = 2; v_syn = 1; ce_div = 1;
    cnt_clr = 1'b1;
    do_reset();
    cnt_clr = 1'b0;
    repeat (5) begin
      pix(0, 0);
      rest(v_tot - 1);
    end
    pix(0, 0);
    chk("sat_c_stb_count", c_stb_n, 0); chk("sat_c_lock_count", c_lk_n, 0);
    chk("sat_c_lk", c_lk, 0); chk("sat_c_ht", c_ht, 0);
    chk("wide_a_lk", a_lk, 1);
    chk("wide_a_ht", a_ht, 800); chk("wide_a_ha", a_ha, 640); chk("wide_a_hs", a_hs, 96);
    chk("wide_a_vt", a_vt, 3); chk("wide_a_va", a_va, 2); chk("wide_a_vs", a_vs, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
